wb_regfile: RTL and testbench
=============================

# wb_regfile

Write-back stage and architectural integer register file for the 5-stage pipeline. It consumes the MEM/WB pipeline register outputs, selects the write-back value, commits it to a 32-entry register file, and serves the two decode-stage read ports with same-cycle write-through bypass. It also exports the committed value for the forwarding unit and keeps a 64-bit retired-instruction counter.

## Interface
Parameters:
- XLEN, 32, data width of registers, ALU result, load data and PC.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- wb_valid  in  1  MEM/WB slot holds a real instruction (0 = bubble).
- rf_en  in  1  instruction writes rd.
- wb_sel  in  2  write-back source: 00 ALU result, 01 load data, 10 PC+4, 11 ALU result.
- read_data  in  XLEN  load data from memory, already sign/zero-extended.
- alu_result  in  XLEN  ALU result.
- rd  in  5  destination register index.
- pc  in  XLEN  PC of the instruction in write-back.
- rs1_addr  in  5  decode read port 1 index.
- rs2_addr  in  5  decode read port 2 index.
- rs1_data  out  XLEN  read port 1 data.
- rs2_data  out  XLEN  read port 2 data.
- fwd_we  out  1  a register write commits this cycle.
- fwd_rd  out  5  index being written (0 when fwd_we = 0).
- fwd_data  out  XLEN  value being written (0 when fwd_we = 0).
- instret  out  64  count of retired (wb_valid) instructions.

## Operation
- wb_data = alu_result / read_data / pc + 4 per wb_sel; PC+4 wraps modulo 2^XLEN (pc = 0xFFFF_FFFC gives 0).
- Commit condition: we = wb_valid & rf_en & (rd != 0) & ~rst.
- On a rising edge with we = 1: regs[rd] <= wb_data. No other entry changes.
- x0: no storage; reads of index 0 always return 0, including under bypass; writes to rd = 0 are discarded and fwd_we stays 0.
- Read ports are combinational from storage, with write-through: if we = 1 and rsN_addr == rd (nonzero), rsN_data = wb_data (the value being written this cycle), not the stale entry. Both ports may hit the same register; both return wb_data.
- fwd_we/fwd_rd/fwd_data are combinational copies of we/rd/wb_data, zeroed when we = 0.
- instret increments by 1 on each rising edge with wb_valid = 1 and rst = 0, regardless of rf_en or rd; it wraps from 2^64-1 to 0.
- Bubble (wb_valid = 0): no write, no count, forwarding outputs zero, even if rf_en = 1.

## Timing
- Reset: on a rising edge with rst = 1, all 31 registers and instret clear to 0. Any write or count presented in that cycle is dropped. rs1_data/rs2_data read 0 and fwd_* are 0 for as long as rst is held and after release until a write occurs.
- Reset released mid-stream: first edge with rst = 0 commits normally; no residual state.
- Write latency: value visible on read ports in the same cycle via bypass; from storage starting the cycle after the edge.
- Read latency: 0 cycles (combinational); rsN_data must not depend on clk.
- instret reflects retirements up to and including the previous edge.
- No backpressure; the block accepts one write-back per cycle unconditionally.

## Test plan
- Reset: preload x5 = 0x1234, assert rst for 1 cycle with a valid write to x6 presented -> x5, x6 read 0, instret = 0.
- Source select: rd = 7, alu_result = 0xAAAA_0001, read_data = 0x5555_0002, pc = 0x100; sweep wb_sel 00/01/10/11 -> x7 = 0xAAAA_0001, 0x5555_0002, 0x104, 0xAAAA_0001; pc = 0xFFFF_FFFC with wb_sel = 10 -> 0x0.
- Bypass: write x9 = 0xDEAD_BEEF while rs1_addr = rs2_addr = 9 -> both ports show 0xDEAD_BEEF in the same cycle, fwd_we = 1, fwd_rd = 9; next cycle storage returns the same value.
- x0: wb_valid = 1, rf_en = 1, rd = 0, alu_result = 0xFFFF_FFFF, rs1_addr = 0 -> rs1_data = 0, fwd_we = 0, instret increments by 1.
- Bubble: wb_valid = 0, rf_en = 1, rd = 3, value 0x77 -> x3 unchanged, fwd_* = 0, instret unchanged.
- Random: 10k cycles of random valid/rf_en/rd/wb_sel/addresses checked against a reference model of regs and instret, including back-to-back writes to the same rd.

Source files
------------

// File: rtl/wb_regfile.sv
// rtl/wb_regfile.sv - write-back source select, 32-entry integer register file, forwarding tap, retire counter
module wb_regfile #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wb_valid,
    input  logic            rf_en,
    input  logic [1:0]      wb_sel,
    input  logic [XLEN-1:0] read_data,
    input  logic [XLEN-1:0] alu_result,
    input  logic [4:0]      rd,
    input  logic [XLEN-1:0] pc,
    input  logic [4:0]      rs1_addr,
    input  logic [4:0]      rs2_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    output logic            fwd_we,
    output logic [4:0]      fwd_rd,
    output logic [XLEN-1:0] fwd_data,
    output logic [63:0]     instret
);

    // x0 has no storage; index 0 is handled by the read muxes
    logic [XLEN-1:0] regs [1:31];
    logic [XLEN-1:0] wb_data;
    logic            we;

    always_comb begin
        wb_data = alu_result;
        case (wb_sel)
            2'b01:   wb_data = read_data;
            2'b10:   wb_data = pc + XLEN'(4);
            default: wb_data = alu_result;
        endcase
    end

    assign we = wb_valid & rf_en & (rd != 5'd0) & ~rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 1; i < 32; i++) begin
                regs[i] <= '0;
            end
            instret <= '0;
        end else begin
            if (we) begin
                regs[rd] <= wb_data;
            end
            if (wb_valid) begin
                instret <= instret + 64'd1;
            end
        end
    end

    // Write-through: a read of the register being committed sees the new value
    always_comb begin
        rs1_data = '0;
        if (!rst && rs1_addr != 5'd0) begin
            rs1_data = (we && rs1_addr == rd) ? wb_data : regs[rs1_addr];
        end
    end

    always_comb begin
        rs2_data = '0;
        if (!rst && rs2_addr != 5'd0) begin
            rs2_data = (we && rs2_addr == rd) ? wb_data : regs[rs2_addr];
        end
    end

    assign fwd_we   = we;
    assign fwd_rd   = we ? rd : 5'd0;
    assign fwd_data = we ? wb_data : '0;

endmodule

// File: tb/tb_wb_regfile.sv
// tb/tb_wb_regfile.sv - scoreboard bench for wb_regfile
module tb_wb_regfile;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_valid;
    logic        rf_en;
    logic [1:0]  wb_sel;
    logic [31:0] read_data;
    logic [31:0] alu_result;
    logic [4:0]  rd;
    logic [31:0] pc;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        fwd_we;
    logic [4:0]  fwd_rd;
    logic [31:0] fwd_data;
    logic [63:0] instret;

    wb_regfile #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .wb_valid(wb_valid), .rf_en(rf_en), .wb_sel(wb_sel),
        .read_data(read_data), .alu_result(alu_result), .rd(rd), .pc(pc),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .fwd_we(fwd_we), .fwd_rd(fwd_rd), .fwd_data(fwd_data), .instret(instret)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_regs [0:31];
    logic [63:0] m_instret;
    logic [63:0] exp_q [$];

    function automatic logic [31:0] model_wb(input logic [1:0] sel, input logic [31:0] alu,
                                             input logic [31:0] ld, input logic [31:0] p);
        case (sel)
            2'b01:   return ld;
            2'b10:   return p + 32'd4;
            default: return alu;
        endcase
    endfunction

    function automatic logic model_we();
        return wb_valid && rf_en && (rd != 5'd0) && !rst;
    endfunction

    function automatic logic [31:0] model_read(input logic [4:0] a);
        if (rst || a == 5'd0) return 32'd0;
        if (model_we() && a == rd) return model_wb(wb_sel, alu_result, read_data, pc);
        return m_regs[a];
    endfunction

    task automatic drive(input logic v, input logic e, input logic [1:0] s, input logic [4:0] d,
                         input logic [31:0] alu, input logic [31:0] ld, input logic [31:0] p,
                         input logic [4:0] a1, input logic [4:0] a2);
        wb_valid = v; rf_en = e; wb_sel = s; rd = d; alu_result = alu;
        read_data = ld; pc = p; rs1_addr = a1; rs2_addr = a2;
    endtask

    // Advance the model across the coming edge, then the DUT
    task automatic tick();
        if (rst) begin
            for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
            m_instret = 64'd0;
        end else begin
            if (model_we()) m_regs[rd] = model_wb(wb_sel, alu_result, read_data, pc);
            if (wb_valid) m_instret = m_instret + 64'd1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [63:0] e;
        drive(1, 1, 2'b00, 5'd5, 32'h1234, 0, 0, 5'd5, 5'd6);
        tick();
        rst = 1'b1;
        drive(1, 1, 2'b00, 5'd6, 32'h5678, 0, 0, 5'd5, 5'd6);
        exp_q.push_back(64'd0);
        exp_q.push_back(64'd0);
        @(negedge clk);
        e = exp_q.pop_front(); checks++;
        if (rs1_data !== e[31:0]) begin errors++; $display("FAIL reset_hold_rs1 got %h want %h", rs1_data, e[31:0]); end
        e = exp_q.pop_front(); checks++;
        if (fwd_we !== e[0]) begin errors++; $display("FAIL reset_hold_fwd_we got %b want %b", fwd_we, e[0]); end
        tick();
        rst = 1'b0;
        drive(0, 0, 2'b00, 5'd0, 0, 0, 0, 5'd5, 5'd6);
        exp_q.push_back(64'd0);
        exp_q.push_back(64'd0);
        exp_q.push_back(64'd0);
        @(negedge clk);
        e = exp_q.pop_front(); checks++;
        if (rs1_data !== e[31:0]) begin errors++; $display("FAIL reset_x5 got %h want %h", rs1_data, e[31:0]); end
        e = exp_q.pop_front(); checks++;
        if (rs2_data !== e[31:0]) begin errors++; $display("FAIL reset_x6 got %h want %h", rs2_data, e[31:0]); end
        e = exp_q.pop_front(); checks++;
        if (instret !== e) begin errors++; $display("FAIL reset_instret got %0d want %0d", instret, e); end
        tick();
    endtask

    task automatic test_source_select();
        logic [63:0] e;
        logic [31:0] want [0:4];
        logic [31:0] pcs  [0:4];
        logic [1:0]  sels [0:4];
        want = '{32'hAAAA_0001, 32'h5555_0002, 32'h0000_0104, 32'hAAAA_0001, 32'h0000_0000};
        pcs  = '{32'h100, 32'h100, 32'h100, 32'h100, 32'hFFFF_FFFC};
        sels = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b10};
        for (int i = 0; i < 5; i++) begin
            drive(1, 1, sels[i], 5'd7, 32'hAAAA_0001, 32'h5555_0002, pcs[i], 5'd1, 5'd2);
            exp_q.push_back({32'd0, want[i]});
            @(negedge clk);
            e = exp_q.pop_front(); checks++;
            if (fwd_data !== e[31:0]) begin errors++; $display("FAIL src_sel%0d_fwd got %h want %h", i, fwd_data, e[31:0]); end
            tick();
            drive(0, 0, 2'b00, 5'd0, 0, 0, 0, 5'd7, 5'd0);
            exp_q.push_back({32'd0, want[i]});
            @(negedge clk);
            e = exp_q.pop_front(); checks++;
            if (rs1_data !== e[31:0]) begin errors++; $display("FAIL src_sel%0d_x7 got %h want %h", i, rs1_data, e[31:0]); end
            tick();
        end
    endtask

    task automatic test_bypass();
        logic [63:0] e;
        drive(1, 1, 2'b00, 5'd9, 32'hDEAD_BEEF, 0, 0, 5'd9, 5'd9);
        exp_q.push_back(64'hDEAD_BEEF);
        exp_q.push_back(64'hDEAD_BEEF);
        exp_q.push_back(64'd1);
        exp_q.push_back(64'd9);
        @(negedge clk);
        e = exp_q.pop_front(); checks++;
        if (rs1_data !== e[31:0]) begin errors++; $display("FAIL bypass_rs1 got %h want %h", rs1_data, e[31:0]); end
        e = exp_q.pop_front(); checks++;
        if (rs2_data !== e[31:0]) begin errors++; $display("FAIL bypass_rs2 got %h want %h", rs2_data, e[31:0]); end
        e = exp_q.pop_front(); checks++;
        if (fwd_we !== e[0]) begin errors++; $display("FAIL bypass_fwd_we got %b want %b", fwd_we, e[0]); end
        e = exp_q.pop_front(); checks++;
        if (fwd_rd !== e[4:0]) begin errors++; $display("FAIL bypass_fwd_rd got %0d want %0d", fwd_rd, e[4:0]); end
        tick();
        drive(0, 0, 2'b00, 5'd0, 0, 0, 0, 5'd9, 5'd9);
        exp_q.push_back(64'hDEAD_BEEF);
        @(negedge clk);
        e = exp_q.pop_front(); checks++;
        if (rs2_data !== e[31:0]) begin errors++; $display("FAIL bypass_stored got %h want %h", rs2_data, e[31:0]); end
        tick();
    endtask

    task automatic test_x0();
        logic [63:0] e;
        logic [63:0] base;
        base = m_instret;
        drive(1, 1, 2'b00, 5'd0, 32'hFFFF_FFFF, 0, 0, 5'd0, 5'd0);
        exp_q.push_back(64'd0);
        exp_q.push_back(64'd0);
        @(negedge clk);
        e = exp_q.pop_front(); checks++;
        if (rs1_data !== e[31:0]) begin errors++; $display("FAIL x0_rs1 got %h want %h", rs1_data, e[31:0]); end
        e = exp_q.pop_front(); checks++;
        if (fwd_we !== e[0]) begin errors++; $display("FAIL x0_fwd_we got %b want %b", fwd_we, e[0]); end
        tick();
        drive(0, 0, 2'b00, 5'd0, 0, 0, 0, 5'd0, 5'd0);
        exp_q.push_back(base + 64'd1);
        @(negedge clk);
        e = exp_q.pop_front(); checks++;
        if (instret !== e) begin errors++; $display("FAIL x0_instret got %0d want %0d", instret, e); end
        tick();
    endtask

    task automatic test_bubble();
        logic [63:0] e;
        logic [63:0] base;
        logic [31:0] old3;
        base = m_instret;
        old3 = m_regs[3];
        drive(0, 1, 2'b00, 5'd3, 32'h77, 0, 0, 5'd3, 5'd0);
        exp_q.push_back({32'd0, old3});
        exp_q.push_back(64'd0);
        exp_q.push_back(64'd0);
        exp_q.push_back(64'd0);
        @(negedge clk);
        e = exp_q.pop_front(); checks++;
        if (rs1_data !== e[31:0]) begin errors++; $display("FAIL bubble_rs1 got %h want %h", rs1_data, e[31:0]); end
        e = exp_q.pop_front(); checks++;
        if (fwd_we !== e[0]) begin errors++; $display("FAIL bubble_fwd_we got %b want %b", fwd_we, e[0]); end
        e = exp_q.pop_front(); checks++;
        if (fwd_rd !== e[4:0]) begin errors++; $display("FAIL bubble_fwd_rd got %0d want %0d", fwd_rd, e[4:0]); end
        e = exp_q.pop_front(); checks++;
        if (fwd_data !== e[31:0]) begin errors++; $display("FAIL bubble_fwd_data got %h want %h", fwd_data, e[31:0]); end
        tick();
        drive(0, 0, 2'b00, 5'd0, 0, 0, 0, 5'd3, 5'd0);
        exp_q.push_back({32'd0, old3});
        exp_q.push_back(base);
        @(negedge clk);
        e = exp_q.pop_front(); checks++;
        if (rs1_data !== e[31:0]) begin errors++; $display("FAIL bubble_x3 got %h want %h", rs1_data, e[31:0]); end
        e = exp_q.pop_front(); checks++;
        if (instret !== e) begin errors++; $display("FAIL bubble_instret got %0d want %0d", instret, e); end
        tick();
    endtask

    task automatic test_random();
        logic [63:0] e;
        logic [4:0]  prev_rd;
        logic        mwe;
        logic [31:0] mwd;
        prev_rd = 5'd1;
        for (int i = 0; i < 10000; i++) begin
            wb_valid   = ($urandom_range(0, 3) != 0);
            rf_en      = $urandom_range(0, 1);
            wb_sel     = 2'($urandom_range(0, 3));
            rd         = ($urandom_range(0, 3) == 0) ? prev_rd : 5'($urandom_range(0, 31));
            alu_result = $urandom;
            read_data  = $urandom;
            pc         = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : $urandom;
            rs1_addr   = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
            rs2_addr   = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
            prev_rd    = rd;
            mwe = model_we();
            mwd = model_wb(wb_sel, alu_result, read_data, pc);
            exp_q.push_back({32'd0, model_read(rs1_addr)});
            exp_q.push_back({32'd0, model_read(rs2_addr)});
            exp_q.push_back({63'd0, mwe});
            exp_q.push_back(mwe ? {59'd0, rd} : 64'd0);
            exp_q.push_back(mwe ? {32'd0, mwd} : 64'd0);
            exp_q.push_back(m_instret);
            @(negedge clk);
            e = exp_q.pop_front(); checks++;
            if (rs1_data !== e[31:0]) begin errors++; $display("FAIL rand%0d_rs1 got %h want %h", i, rs1_data, e[31:0]); end
            e = exp_q.pop_front(); checks++;
            if (rs2_data !== e[31:0]) begin errors++; $display("FAIL rand%0d_rs2 got %h want %h", i, rs2_data, e[31:0]); end
            e = exp_q.pop_front(); checks++;
            if (fwd_we !== e[0]) begin errors++; $display("FAIL rand%0d_fwd_we got %b want %b", i, fwd_we, e[0]); end
            e = exp_q.pop_front(); checks++;
            if (fwd_rd !== e[4:0]) begin errors++; $display("FAIL rand%0d_fwd_rd got %0d want %0d", i, fwd_rd, e[4:0]); end
            e = exp_q.pop_front(); checks++;
            if (fwd_data !== e[31:0]) begin errors++; $display("FAIL rand%0d_fwd_data got %h want %h", i, fwd_data, e[31:0]); end
            e = exp_q.pop_front(); checks++;
            if (instret !== e) begin errors++; $display("FAIL rand%0d_instret got %0d want %0d", i, instret, e); end
            tick();
        end
    endtask

    initial begin
        rst = 1'b1;
        drive(0, 0, 2'b00, 5'd0, 0, 0, 0, 5'd0, 5'd0);
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        m_instret = 64'd0;
        tick();
        tick();
        rst = 1'b0;
        test_reset();
        test_source_select();
        test_bypass();
        test_x0();
        test_bubble();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
